// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Parameter legality helpers are evaluated at elaboration time.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic calc_parity(
    input logic [8:0] data,
    input logic       odd
  );
    return (^data) ^ odd;
  endfunction

  function automatic bit os_ok(input int os);
    return (os % 2 == 0) && (os >= 8);
  endfunction

  function automatic bit stop_ok(input int s);
    return (s == 1) || (s == 2);
  endfunction

  function automatic bit data_ok(input int d);
    return (d >= 5) && (d <= 9);
  endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser for the async rx pad plus a 2-of-3
// majority over the current and two previous synchronised samples.
module uart_rx_sync_vote (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic rxs_o,
  output logic prev_o,
  output logic maj_o
);

  logic       s1_q;
  logic       s2_q;
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 2'b11;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      hist_q <= {hist_q[0], s2_q};
    end
  end

  assign rxs_o  = s2_q;
  assign prev_o = hist_q[0];
  assign maj_o  = (s2_q & hist_q[0])
                | (s2_q & hist_q[1])
                | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: voted bit decisions, one-entry
// holding register with valid/ready, error sideband, sticky overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] CNT_WRAP = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       ODD       = 1'(PARITY_ODD);

  if (!(os_ok(OVERSAMPLE) && stop_ok(STOP_BITS) && data_ok(DATA_BITS)))
  begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter set");
  end

  logic rxs;
  logic rxs_prev;
  logic maj;

  uart_rx_sync_vote u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_i   (rx),
    .rxs_o  (rxs),
    .prev_o (rxs_prev),
    .maj_o  (maj)
  );

  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 ferr_q;
  logic                 zero_q;

  logic dec;
  logic wrap;
  logic perr;

  assign dec  = (cnt_q == CNT_DEC);
  assign wrap = (cnt_q == CNT_WRAP);
  assign perr = (PARITY_EN != 0)
              && (par_q != calc_parity(9'(shift_q), ODD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_q     <= 1'b0;
      zero_q     <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      if (state_q != IDLE && !en) begin
        state_q <= IDLE;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            // falling edge only, so a held-low line cannot retrigger
            if (en && !rxs && rxs_prev) begin
              state_q <= START;
              cnt_q   <= CW'(1);
              bit_q   <= '0;
              busy    <= 1'b1;
              zero_q  <= 1'b1;
              ferr_q  <= 1'b0;
            end
          end
          START: begin
            if (dec && maj) begin
              state_q <= IDLE;
              busy    <= 1'b0;
            end else if (wrap) begin
              state_q <= DATA;
            end
          end
          DATA: begin
            if (dec) begin
              shift_q <= {maj, shift_q[DATA_BITS-1:1]};
              if (maj) zero_q <= 1'b0;
            end
            if (wrap) begin
              if (bit_q == LAST_DATA) begin
                bit_q   <= '0;
                state_q <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_q <= bit_q + 4'd1;
              end
            end
          end
          PARITY: begin
            if (dec) begin
              par_q <= maj;
              if (maj) zero_q <= 1'b0;
            end
            if (wrap) state_q <= STOP;
          end
          STOP: begin
            if (dec && bit_q == LAST_STOP) begin
              state_q <= IDLE;
              busy    <= 1'b0;
              if (!valid || ready) begin
                data_out   <= shift_q;
                parity_err <= perr;
                frame_err  <= ferr_q | ~maj;
                break_det  <= zero_q & ~maj;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              if (dec && !maj) ferr_q <= 1'b1;
              if (dec && maj) zero_q <= 1'b0;
              if (wrap) bit_q <= bit_q + 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule
